sys_input_debounce: RTL and testbench
=====================================

SYS_INPUT_DEBOUNCE -- requirements
Module: sys_input_debounce

Interface
REQ-001 Parameter WIDTH, default 32: number of independent input channels.
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer flop depth per channel; legal values are 2 or more.
REQ-003 Parameter DEBOUNCE_CYCLES, default 1000: number of qualifying tick edges a new level must persist before acceptance; legal values are 1 or more.
REQ-004 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 Port raw_in, input, WIDTH bits: asynchronous external pins.
REQ-007 Port tick, input, 1 bit: debounce counter advance enable; tie to 1 for per-cycle counting.
REQ-008 Port data_out, output, WIDTH bits: registered debounced levels; drives the PIO input port directly.
REQ-009 Port rise_pulse, output, WIDTH bits: registered one-cycle pulse per channel on an accepted 0->1 transition.
REQ-010 Port fall_pulse, output, WIDTH bits: registered one-cycle pulse per channel on an accepted 1->0 transition.
REQ-011 Port edge_any, output, 1 bit: registered OR of all rise_pulse and fall_pulse bits in the same cycle.

Function
REQ-012 Each channel SHALL be fully independent, with its own sync chain, stable register, counter and pulse flops.
- No channel's state shall depend on another channel's state.
REQ-013 raw_in[i] SHALL pass through SYNC_STAGES flops; sync_out[i] is the last flop.
- No other logic SHALL touch raw_in.
REQ-014 Counter width SHALL be clog2(DEBOUNCE_CYCLES)+1 bits.
- The counter SHALL never wrap: it saturates at DEBOUNCE_CYCLES-1 at most.
REQ-015 While sync_out[i] == data_out[i], counter[i] SHALL clear to 0 on every edge, regardless of tick.
REQ-016 While sync_out[i] != data_out[i], tick=0: counter[i] SHALL hold.
REQ-017 While sync_out[i] != data_out[i], tick=1, counter < DEBOUNCE_CYCLES-1: counter[i] SHALL increment by 1.
REQ-018 While sync_out[i] != data_out[i], tick=1, counter == DEBOUNCE_CYCLES-1: on that edge data_out[i] SHALL load sync_out[i] and counter[i] SHALL clear.
REQ-019 A mismatch that disappears before acceptance (a glitch) SHALL clear the counter.
- data_out SHALL be unchanged.
- No pulse SHALL fire.
REQ-020 Latency with tick=1: data_out[i] SHALL update on the (SYNC_STAGES+DEBOUNCE_CYCLES)th rising edge that samples the new raw level.
- The edge that first samples the new level counts as edge 1.
- Edges follow on continuously, and raw_in is held steady throughout.
REQ-021 rise_pulse[i]/fall_pulse[i] SHALL assert on the same edge data_out[i] updates.
- They SHALL stay high for exactly one cycle.
- They SHALL deassert on the next edge unless a further acceptance occurs on that edge.
REQ-022 edge_any SHALL be registered from the next-state pulse vector, so it is coincident with the pulses, not one cycle later.
REQ-023 Simultaneous acceptances on multiple channels SHALL all pulse in the same cycle.
REQ-024 DEBOUNCE_CYCLES=1: acceptance SHALL occur on the first tick edge with a mismatch.
REQ-025 Behaviour SHALL be identical for rising and falling transitions.

Reset
REQ-026 With reset=1 at a rising edge, the following SHALL be 0: all sync flops, data_out, counters, rise_pulse, fall_pulse and edge_any.
REQ-027 Reset SHALL take priority over tick and over any pending acceptance.
- A count in progress SHALL be discarded.
REQ-028 After reset release with raw_in[i]=1, channel i SHALL be treated as a normal 0->1 transition.
- data_out[i] SHALL rise after the REQ-020 latency.
- rise_pulse[i] SHALL fire.

Verification
REQ-029 Latency check (WIDTH=4, DEBOUNCE_CYCLES=4, tick=1): raw_in 0->1 on bit 0, held.
- data_out[0] SHALL go high on the 6th edge.
- rise_pulse[0] and edge_any SHALL go high for one cycle on that same edge.
REQ-030 Glitch check (same configuration): a 3-cycle high pulse on raw_in[1], then low -> data_out, rise_pulse and fall_pulse SHALL all remain 0.
REQ-031 Tick gating check: tick high every 3rd cycle, DEBOUNCE_CYCLES=2, raw_in[2] 0->1 held.
- Acceptance SHALL occur on the 2nd tick edge after sync_out mismatches.
- No acceptance SHALL occur between ticks.
REQ-032 Simultaneous check: raw_in 4'b0000->4'b1010 then, after acceptance, ->4'b0101.
- First change: rise_pulse SHALL be 4'b1010 and fall_pulse 0 in the same cycle.
- Second change: rise_pulse SHALL be 4'b0101 and fall_pulse 4'b1010 in the same cycle.
- edge_any SHALL be 1 each time.
REQ-033 Reset mid-count check: reset asserted with counter[0]=2.
- Next edge: all outputs 0, counter 0.
- After release with raw_in[0]=1: full REQ-020 latency from restart, then rise_pulse[0].

Source files
------------

// File: rtl/sys_input_debounce.sv
// Multi-channel input debouncer: per-channel synchronizer, tick-gated stability
// counter, registered debounced level and one-cycle rise/fall pulses.

module sys_input_debounce_lane #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int CW              = $clog2(DEBOUNCE_CYCLES) + 1
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  input  logic tick,
  output logic level,
  output logic rise,
  output logic fall,
  output logic rise_nxt,
  output logic fall_nxt
);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt, cnt_nxt;
  logic                   level_nxt;
  logic                   sync_out;

  assign sync_out = sync_q[SYNC_STAGES-1];

  always_comb begin
    cnt_nxt   = cnt;
    level_nxt = level;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    if (sync_out == level) begin
      cnt_nxt = '0;
    end else if (tick) begin
      // >= keeps the counter from ever wrapping past the acceptance point
      if (cnt >= CNT_MAX) begin
        level_nxt = sync_out;
        cnt_nxt   = '0;
        rise_nxt  = sync_out;
        fall_nxt  = ~sync_out;
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      cnt    <= '0;
      level  <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
      cnt    <= cnt_nxt;
      level  <= level_nxt;
      rise   <= rise_nxt;
      fall   <= fall_nxt;
    end
  end
endmodule

module sys_input_debounce #(
  parameter int WIDTH           = 32,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw_in,
  input  logic             tick,
  output logic [WIDTH-1:0] data_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic             edge_any
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;

  logic [WIDTH-1:0] rise_nxt, fall_nxt;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    sys_input_debounce_lane #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CW             (CW)
    ) u_lane (
      .clk     (clk),
      .reset   (reset),
      .raw     (raw_in[i]),
      .tick    (tick),
      .level   (data_out[i]),
      .rise    (rise_pulse[i]),
      .fall    (fall_pulse[i]),
      .rise_nxt(rise_nxt[i]),
      .fall_nxt(fall_nxt[i])
    );
  end

  // Built from next-state pulses so it lands in the same cycle as the pulses
  always_ff @(posedge clk) begin
    if (reset) edge_any <= 1'b0;
    else       edge_any <= |(rise_nxt | fall_nxt);
  end
endmodule

// File: tb/tb_sys_input_debounce.sv
// Randomized + directed bench for sys_input_debounce; expected outputs come from a
// sample-history reference model and are checked by a decoupled monitor.

module tb_sys_input_debounce;
  localparam int W  = 4;
  localparam int SS = 2;
  localparam int DC = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] raw_in = '0;
  logic         tick = 1'b1;
  logic [W-1:0] data_out, rise_pulse, fall_pulse;
  logic         edge_any;

  sys_input_debounce #(.WIDTH(W), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .raw_in(raw_in), .tick(tick),
    .data_out(data_out), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
    .edge_any(edge_any)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] data;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic         any;
  } exp_t;

  exp_t         exp_q[$];
  int           checks = 0;
  int           errors = 0;
  bit           done = 1'b0;

  // Reference model: raw samples age through a history queue; a channel accepts
  // once its delayed sample has disagreed with the held level for DC tick edges in a row.
  logic [W-1:0] m_hist[$];
  logic [W-1:0] m_data = '0;
  int           m_run[W];

  task automatic step(input logic [W-1:0] r, input logic t, input logic rs);
    exp_t         e;
    logic [W-1:0] seen;
    raw_in = r; tick = t; reset = rs;
    e = '0;
    seen = m_hist[SS-1];
    if (rs) begin
      for (int k = 0; k < SS; k++) m_hist[k] = '0;
      m_data = '0;
      for (int c = 0; c < W; c++) m_run[c] = 0;
    end else begin
      for (int c = 0; c < W; c++) begin
        if (seen[c] == m_data[c]) m_run[c] = 0;
        else if (t) begin
          m_run[c]++;
          if (m_run[c] == DC) begin
            m_run[c] = 0;
            m_data[c] = seen[c];
            if (seen[c]) e.rise[c] = 1'b1;
            else         e.fall[c] = 1'b1;
          end
        end
      end
      m_hist.push_front(r);
      void'(m_hist.pop_back());
    end
    e.data = m_data;
    e.any  = |(e.rise | e.fall);
    exp_q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: one expected entry per rising edge, compared on the falling edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        if (!done) begin
          checks++; errors++;
          $display("FAIL scoreboard_empty: got no entry expected one (t=%0t)", $time);
        end
      end else begin
        e = exp_q.pop_front();
        chk("data_out",   data_out,   e.data);
        chk("rise_pulse", rise_pulse, e.rise);
        chk("fall_pulse", fall_pulse, e.fall);
        chk("edge_any",   {{(W-1){1'b0}}, edge_any}, {{(W-1){1'b0}}, e.any});
      end
    end
  end

  initial begin
    logic [W-1:0] r;
    logic         t;
    int           edge_n;
    for (int k = 0; k < SS; k++) m_hist.push_back('0);
    for (int c = 0; c < W; c++) m_run[c] = 0;

    step('0, 1'b1, 1'b1);
    step('0, 1'b1, 1'b1);
    step('0, 1'b1, 1'b0);

    // Latency: bit 0 rises and is held; acceptance expected on edge SS+DC
    edge_n = 0;
    for (int i = 0; i < 10; i++) begin
      step(4'b0001, 1'b1, 1'b0);
      edge_n++;
      if (edge_n == SS + DC - 1) chk("latency_pre", data_out, 4'b0000);
      if (edge_n == SS + DC) begin
        chk("latency_data", data_out, 4'b0001);
        chk("latency_rise", rise_pulse, 4'b0001);
      end
    end

    // Glitch: 3-cycle high on bit 1 must never be accepted
    for (int i = 0; i < 3; i++) step(4'b0011, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) step(4'b0001, 1'b1, 1'b0);
    chk("glitch_data", data_out, 4'b0001);

    // Tick gating: tick every 3rd cycle on bit 2
    for (int i = 0; i < 24; i++) step(4'b0101, (i % 3) == 2, 1'b0);
    chk("tick_gate_data", data_out, 4'b0101);

    // Simultaneous acceptances
    for (int i = 0; i < 10; i++) step(4'b1010, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) step(4'b0101, 1'b1, 1'b0);
    chk("simul_data", data_out, 4'b0101);

    // Reset mid-count, then restart with bit 0 high
    step('0, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) step('0, 1'b1, 1'b0);
    for (int i = 0; i < SS + 2; i++) step(4'b0001, 1'b1, 1'b0);
    step(4'b0001, 1'b1, 1'b1);
    chk("reset_data", data_out, 4'b0000);
    for (int i = 0; i < 10; i++) step(4'b0001, 1'b1, 1'b0);
    chk("restart_data", data_out, 4'b0001);

    // Random: sparse level flips (mix of glitches and real changes), random tick
    r = 4'b0001;
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < W; c++)
        if ($urandom_range(0, 11) == 0) r[c] = ~r[c];
      t = ($urandom_range(0, 3) != 0);
      step(r, t, $urandom_range(0, 399) == 0);
    end

    @(negedge clk); #1;
    done = 1'b1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
